// File: rtl/fifo_stream_adapter.sv
// Credit-based adapter from a fixed-latency FIFO read port (may_pop/pop/pop_data)
// to a valid/ready stream, using a small skid buffer that always has room for every in-flight read.
module fifo_stream_adapter #(
  parameter int WIDTH        = 8,
  parameter int READ_LATENCY = 2,
  parameter int BUF_DEPTH    = READ_LATENCY + 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               fifo_may_pop,
  output logic                               fifo_pop,
  input  logic [WIDTH-1:0]                   fifo_pop_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WIDTH-1:0]                   out_data,
  output logic [$clog2(BUF_DEPTH+1)-1:0]     occupancy
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam int IW = $clog2(READ_LATENCY + 1);
  localparam int SW = OW + 1;

  logic [WIDTH-1:0]        buf_q [0:BUF_DEPTH-1];
  logic [PW-1:0]           rptr_q, rptr_d;
  logic [PW-1:0]           wptr_q, wptr_d;
  logic [OW-1:0]           occ_q, occ_d;
  logic [READ_LATENCY-1:0] infl_q, infl_d;
  logic [IW-1:0]           infl_cnt_q, infl_cnt_d;
  logic [SW-1:0]           credit_used;
  logic                    arrive;
  logic                    fire;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    arrive      = infl_q[READ_LATENCY-1];
    out_valid   = (occ_q != '0);
    out_data    = buf_q[rptr_q];
    occupancy   = occ_q;
    fire        = out_valid && out_ready;
    // Credit uses only registered counts, so out_ready never reaches fifo_pop.
    credit_used = SW'(occ_q) + SW'(infl_cnt_q);
    fifo_pop    = rst_n && fifo_may_pop && (credit_used < SW'(BUF_DEPTH));

    infl_d     = (infl_q << 1) | READ_LATENCY'(fifo_pop);
    infl_cnt_d = infl_cnt_q + IW'(fifo_pop) - IW'(arrive);
    occ_d      = occ_q + OW'(arrive) - OW'(fire);
    wptr_d     = arrive ? ptr_inc(wptr_q) : wptr_q;
    rptr_d     = fire   ? ptr_inc(rptr_q) : rptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr_q     <= '0;
      wptr_q     <= '0;
      occ_q      <= '0;
      infl_q     <= '0;
      infl_cnt_q <= '0;
    end else begin
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      occ_q      <= occ_d;
      infl_q     <= infl_d;
      infl_cnt_q <= infl_cnt_d;
    end
  end

  // Storage is not reset; out_data is meaningless while out_valid is low.
  always_ff @(posedge clk) begin
    if (arrive) buf_q[wptr_q] <= fifo_pop_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(arrive && (occ_q == OW'(BUF_DEPTH)) && !fire));

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Bench for fifo_stream_adapter: a behavioural 2-cycle-latency FIFO feeds either a
// default-depth instance or a BUF_DEPTH=3 instance; a scoreboard checks every delivered word.
module tb_fifo_stream_adapter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       out_ready = 1'b0;
  logic       sel = 1'b0;
  logic       push_en = 1'b0;
  logic [7:0] push_val = 8'h00;

  logic       pop_a, pop_b, valid_a, valid_b;
  logic [7:0] data_a, data_b;
  logic [2:0] occ_a;
  logic [1:0] occ_b;

  logic [7:0] fm [0:63];
  logic [5:0] fwp, frp;
  logic [6:0] fcnt;
  logic [7:0] s1_data, src_data;
  logic       fmay, src_pop;

  always #5 clk = ~clk;

  assign fmay    = (fcnt != 7'd0);
  assign src_pop = sel ? pop_b : pop_a;

  // Source FIFO model: pop in cycle t -> data presented during cycle t+2.
  always @(posedge clk) begin
    if (!rst_n) begin
      fwp  <= '0;
      frp  <= '0;
      fcnt <= '0;
    end else begin
      if (push_en) begin
        fm[fwp] <= push_val;
        fwp     <= fwp + 6'd1;
      end
      if (src_pop) begin
        s1_data <= fm[frp];
        frp     <= frp + 6'd1;
      end
      fcnt <= fcnt + 7'(push_en) - 7'(src_pop);
    end
    src_data <= s1_data;
  end

  fifo_stream_adapter dut_a (
    .clk(clk), .rst_n(rst_n), .fifo_may_pop(fmay && !sel), .fifo_pop(pop_a),
    .fifo_pop_data(src_data), .out_valid(valid_a), .out_ready(out_ready),
    .out_data(data_a), .occupancy(occ_a));

  fifo_stream_adapter #(.WIDTH(8), .READ_LATENCY(2), .BUF_DEPTH(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .fifo_may_pop(fmay && sel), .fifo_pop(pop_b),
    .fifo_pop_data(src_data), .out_valid(valid_b), .out_ready(out_ready),
    .out_data(data_b), .occupancy(occ_b));

  logic       mon_valid, mon_pop;
  logic [7:0] mon_data;
  logic [2:0] mon_occ;
  assign mon_valid = sel ? valid_b : valid_a;
  assign mon_pop   = sel ? pop_b : pop_a;
  assign mon_data  = sel ? data_b : data_a;
  assign mon_occ   = sel ? {1'b0, occ_b} : occ_a;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q [$];
  int cycle = 0;
  int n_fire, n_pop, first_fire, last_fire, first_pop, first_valid, pop_bad, max_occ;

  typedef struct {
    logic       push;
    logic [7:0] val;
    logic       rdy;
    logic       e_valid;
    logic [7:0] e_data;
    logic [2:0] e_occ;
    logic       e_pop;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic clr_stats();
    n_fire = 0; n_pop = 0; pop_bad = 0; max_occ = 0;
    first_fire = -1; last_fire = -1; first_pop = -1; first_valid = -1;
  endtask

  task automatic push(input logic [7:0] v);
    push_en  = 1'b1;
    push_val = v;
    exp_q.push_back(v);
  endtask

  // Sample the current cycle, then advance one clock.
  task automatic cyc();
    if (mon_valid && out_ready) begin
      n_fire++;
      if (first_fire < 0) first_fire = cycle;
      last_fire = cycle;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_word: got %0h want none", mon_data);
      end else begin
        check("order", {24'd0, mon_data}, {24'd0, exp_q.pop_front()});
      end
    end
    if (mon_pop) begin
      n_pop++;
      if (first_pop < 0) first_pop = cycle;
    end
    if (mon_valid && first_valid < 0) first_valid = cycle;
    if (!fmay && mon_pop) pop_bad++;
    if (int'(mon_occ) > max_occ) max_occ = int'(mon_occ);
    @(posedge clk);
    #1;
    push_en = 1'b0;
    cycle++;
  endtask

  task automatic drain(input int maxc, input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || mon_valid) && n < maxc) begin
      cyc();
      n++;
    end
    check({nm, "_left"}, exp_q.size(), 0);
    check({nm, "_idle"}, {31'd0, mon_valid}, 0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 3'd1, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 3'd2, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 3'd1, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
    clr_stats();

    // Reset state
    repeat (3) cyc();
    check("rst_valid", {31'd0, valid_a}, 0);
    check("rst_pop", {31'd0, pop_a}, 0);
    check("rst_occ", {29'd0, occ_a}, 0);
    check("rst_valid_b", {31'd0, valid_b}, 0);
    rst_n = 1'b1;

    // Cycle-accurate table
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].push) push(tbl[i].val);
      out_ready = tbl[i].rdy;
      check($sformatf("tbl%0d_valid", i), {31'd0, mon_valid}, {31'd0, tbl[i].e_valid});
      check($sformatf("tbl%0d_occ", i), {29'd0, mon_occ}, {29'd0, tbl[i].e_occ});
      check($sformatf("tbl%0d_pop", i), {31'd0, mon_pop}, {31'd0, tbl[i].e_pop});
      if (tbl[i].e_valid)
        check($sformatf("tbl%0d_data", i), {24'd0, mon_data}, {24'd0, tbl[i].e_data});
      cyc();
    end
    drain(10, "tbl");

    // Streaming 0x01..0x10
    clr_stats();
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      push(8'(i));
      cyc();
    end
    drain(40, "stream");
    check("stream_fires", n_fire, 16);
    check("stream_latency", first_valid - first_pop, 3);
    check("stream_back2back", last_fire - first_fire, 15);

    // Full backpressure
    clr_stats();
    out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      push(8'(i));
      cyc();
    end
    repeat (10) cyc();
    check("bp_pops", n_pop, 4);
    check("bp_occ", {29'd0, mon_occ}, 4);
    check("bp_pop_idle", {31'd0, mon_pop}, 0);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", {31'd0, mon_valid}, 1);
      check("bp_hold_data", {24'd0, mon_data}, 32'h01);
      cyc();
    end
    out_ready = 1'b1;
    drain(40, "bp");
    check("bp_fires", n_fire, 10);

    // Alternating out_ready with a continuous source
    clr_stats();
    for (int i = 0; i < 60; i++) begin
      out_ready = (i % 2 == 0);
      if (i < 12) push(8'h60 + 8'(i));
      cyc();
    end
    out_ready = 1'b1;
    drain(10, "alt");
    check("alt_fires", n_fire, 12);
    check("alt_max_occ", max_occ <= 4, 1);

    // Empty gap
    clr_stats();
    push(8'h21); cyc();
    push(8'h22); cyc();
    repeat (20) cyc();
    check("gap_valid_low", {31'd0, mon_valid}, 0);
    check("gap_fires2", n_fire, 2);
    push(8'h23); cyc();
    drain(20, "gap");
    check("gap_fires3", n_fire, 3);
    check("gap_pop_when_empty", pop_bad, 0);

    // Reset mid-stream with two reads in flight and two buffered
    clr_stats();
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (mon_occ == 3'd2) break;
      if (k < 6) push(8'h31 + 8'(k));
      cyc();
    end
    check("mid_occ_reach2", {29'd0, mon_occ}, 2);
    rst_n = 1'b0;
    exp_q.delete();
    cyc();
    check("mid_rst_occ", {29'd0, mon_occ}, 0);
    check("mid_rst_valid", {31'd0, mon_valid}, 0);
    check("mid_rst_pop", {31'd0, mon_pop}, 0);
    rst_n = 1'b1;
    clr_stats();
    out_ready = 1'b1;
    push(8'hA5);
    repeat (15) cyc();
    check("mid_one_word", n_fire, 1);
    check("mid_left", exp_q.size(), 0);

    // Minimum depth instance
    sel = 1'b1;
    clr_stats();
    begin
      int f1;
      f1 = 0;
      for (int i = 0; i < 24; i++) begin
        if (i == 10) f1 = n_fire;
        if (i == 22) check("d3_throughput", (n_fire - f1) >= 8, 1);
        push(8'h41 + 8'(i));
        cyc();
      end
    end
    drain(60, "d3");
    check("d3_fires", n_fire, 24);
    check("d3_max_occ", max_occ <= 3, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
